sqrt_core: RTL

SQRT_CORE -- requirements
Module: sqrt_core

---
 rtl/sqrt_core.sv | 118 +++++++++++
 1 files changed

// File: rtl/sqrt_core.sv
// sqrt_core: iterative restoring integer square root.
// Produces one root bit per cycle: floor(sqrt(x)) and the remainder x - root^2.
// Handshake is start/ready with a one-cycle done pulse. Results hold until the next completion.
module sqrt_core #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                    ACLK,
  input  logic                    ARESETN,
  input  logic                    start,
  input  logic [DATA_WIDTH-1:0]   x_in,
  output logic                    ready,
  output logic                    done,
  output logic [DATA_WIDTH/2-1:0] result,
  output logic [DATA_WIDTH/2:0]   remainder
);

  localparam int HALF = DATA_WIDTH / 2;
  localparam int TW   = HALF + 3;
  localparam int CW   = (HALF > 2) ? $clog2(HALF) : 1;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t              state, state_next;
  logic [DATA_WIDTH-1:0] x_sh;
  logic [HALF-1:0]     root;
  logic [HALF:0]       rem;
  logic [CW-1:0]       cnt;
  logic [HALF-1:0]     root_step;
  logic [HALF:0]       rem_step;

  // One restoring digit step. Before any step the partial remainder is below 2^HALF,
  // so {rem, pair} never sets the trial MSB and that MSB is a true sign bit.
  function automatic logic [2*HALF:0] digit_step(
    input logic [HALF-1:0] root_in,
    input logic [HALF:0]   rem_in,
    input logic [1:0]      pair
  );
    logic signed [TW-1:0] trial;
    logic [HALF-1:0]      root_out;
    logic [HALF:0]        rem_out;
    trial = signed'({rem_in, pair}) - signed'({1'b0, root_in, 2'b01});
    if (!trial[TW-1]) begin
      rem_out  = trial[HALF:0];
      root_out = {root_in[HALF-2:0], 1'b1};
    end else begin
      rem_out  = {rem_in[HALF-2:0], pair};
      root_out = {root_in[HALF-2:0], 1'b0};
    end
    return {root_out, rem_out};
  endfunction

  // Combinational digit step on the current partial state and the top radicand pair.
  always_comb begin
    {root_step, rem_step} = digit_step(root, rem, x_sh[DATA_WIDTH-1:DATA_WIDTH-2]);
  end

  // State register.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) state <= IDLE;
    else          state <= state_next;
  end

  // Next-state and handshake outputs.
  always_comb begin
    state_next = state;
    ready      = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: begin
        ready = 1'b1;
        if (start) state_next = CALC;
      end
      CALC: begin
        if (cnt == '0) state_next = DONE;
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Datapath: load on acceptance, iterate in CALC, publish results on entry to DONE.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      x_sh      <= '0;
      root      <= '0;
      rem       <= '0;
      cnt       <= '0;
      result    <= '0;
      remainder <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            x_sh <= x_in;
            root <= '0;
            rem  <= '0;
            cnt  <= CW'(HALF - 1);
          end
        end
        CALC: begin
          x_sh <= {x_sh[DATA_WIDTH-3:0], 2'b00};
          root <= root_step;
          rem  <= rem_step;
          cnt  <= cnt - 1'b1;
          if (cnt == '0) begin
            result    <= root_step;
            remainder <= rem_step;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
